// File: rtl/spi_if.sv
// Request/status and SPI pin bundle for spi_master.
// The master modport is the engine side; the slave modport is the requesting/observing side.
interface spi_if #(
    parameter int DATA_W = 4
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              mosi;
    logic              ss;

    modport master (
        input  start,
        input  data_in,
        output busy,
        output done,
        output sclk,
        output mosi,
        output ss
    );

    modport slave (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  sclk,
        input  mosi,
        input  ss
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-3 (CPOL=1, CPHA=1) master: one DATA_W-bit word per frame, MSB first,
// with a lead-in half period before the first falling edge and a gap after the frame.
module spi_master #(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    spi_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              high_half_reg, high_half_next;
    logic              ss_reg, ss_next;
    logic              sclk_reg, sclk_next;
    logic              mosi_reg, mosi_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic              div_end;
    logic [DATA_W-1:0] shifted;

    assign div_end = (div_reg == DIV_LAST);
    assign shifted = shift_reg << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            high_half_reg <= 1'b0;
            ss_reg        <= 1'b1;
            sclk_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            high_half_reg <= high_half_next;
            ss_reg        <= ss_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        high_half_next = high_half_reg;
        ss_next        = ss_reg;
        sclk_next      = sclk_reg;
        mosi_next      = mosi_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next     = LEAD;
                    shift_next     = bus.data_in;
                    div_next       = '0;
                    bit_next       = '0;
                    high_half_next = 1'b0;
                    ss_next        = 1'b0;
                    busy_next      = 1'b1;
                end
            end
            LEAD: begin
                if (div_end) begin
                    state_next     = SHIFT;
                    div_next       = '0;
                    sclk_next      = 1'b0;
                    mosi_next      = shift_reg[DATA_W-1];
                    high_half_next = 1'b0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_next = div_reg + 1'b1;
                end else begin
                    div_next = '0;
                    if (!high_half_reg) begin
                        sclk_next      = 1'b1;
                        high_half_next = 1'b1;
                    end else begin
                        // Bit finished: advance the word and either fall again or close the frame.
                        shift_next     = shifted;
                        high_half_next = 1'b0;
                        if (bit_reg == BIT_LAST) begin
                            state_next = GAP;
                            bit_next   = '0;
                            ss_next    = 1'b1;
                            mosi_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            bit_next  = bit_reg + 1'b1;
                            sclk_next = 1'b0;
                            mosi_next = shifted[DATA_W-1];
                        end
                    end
                end
            end
            GAP: begin
                // The done cycle is the first gap cycle; start is not sampled here.
                if (div_end) begin
                    state_next = IDLE;
                    div_next   = '0;
                    busy_next  = 1'b0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ss   = ss_reg;
    assign bus.sclk = sclk_reg;
    assign bus.mosi = mosi_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default (4-bit, div 2) and fast (8-bit, div 1) instances.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_if #(.DATA_W(4)) bus_a ();
    spi_if #(.DATA_W(8)) bus_b ();

    spi_master #(.DATA_W(4), .CLK_DIV(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    spi_master #(.DATA_W(8), .CLK_DIV(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ss, sclk, mosi, busy, done}
    function automatic logic [4:0] outs(input bit sel);
        if (sel)
            return {bus_b.ss, bus_b.sclk, bus_b.mosi, bus_b.busy, bus_b.done};
        return {bus_a.ss, bus_a.sclk, bus_a.mosi, bus_a.busy, bus_a.done};
    endfunction

    task automatic drive(input bit sel, input logic s, input logic [7:0] d);
        if (sel) begin
            bus_b.start   = s;
            bus_b.data_in = d;
        end else begin
            bus_a.start   = s;
            bus_a.data_in = d[3:0];
        end
    endtask

    // Start a frame in cycle T0, then record every cycle T1..gap end+3 and compare whole waveforms.
    task automatic run_frame(input bit sel, input int cd, input int dw, input logic [7:0] word,
                             input int chg_t, input logic [7:0] chg_val,
                             input int pulse_a, input int pulse_b, input string tag);
        int ss_end, done_t, idle_t, last_t, nrise;
        logic [63:0] got_ss, got_sclk, got_done, got_busy;
        logic [63:0] exp_ss, exp_sclk, exp_done, exp_busy;
        logic [7:0] rx, mask, cur;
        logic [4:0] o;
        bit prev_sclk, mosi_bad;
        ss_end = cd * (1 + 2 * dw);
        done_t = ss_end + 1;
        idle_t = done_t + cd;
        last_t = idle_t + 3;
        got_ss = '0; got_sclk = '0; got_done = '0; got_busy = '0;
        exp_ss = '0; exp_sclk = '0; exp_done = '0; exp_busy = '0;
        rx = '0; nrise = 0; prev_sclk = 1'b1; mosi_bad = 1'b0;
        mask = '0;
        for (int i = 0; i < dw; i++) mask[i] = 1'b1;
        cur = word;
        @(negedge clk);
        drive(sel, 1'b1, cur);
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            o = outs(sel);
            got_ss[t]   = o[4];
            got_sclk[t] = o[3];
            got_busy[t] = o[1];
            got_done[t] = o[0];
            if (o[4] && o[2]) mosi_bad = 1'b1;
            if (!prev_sclk && o[3]) begin
                rx = {rx[6:0], o[2]};
                nrise++;
            end
            prev_sclk = o[3];
            exp_ss[t]   = (t > ss_end);
            exp_sclk[t] = !(t > cd && t <= ss_end && ((t - cd - 1) % (2 * cd)) < cd);
            exp_done[t] = (t == done_t);
            exp_busy[t] = (t < idle_t);
            if (t == chg_t) cur = chg_val;
            drive(sel, (t == pulse_a || t == pulse_b), cur);
        end
        drive(sel, 1'b0, cur);
        check_val({tag, ".ss"}, got_ss, exp_ss);
        check_val({tag, ".sclk"}, got_sclk, exp_sclk);
        check_val({tag, ".done"}, got_done, exp_done);
        check_val({tag, ".busy"}, got_busy, exp_busy);
        check_val({tag, ".rx"}, rx & mask, word & mask);
        check_val({tag, ".rises"}, nrise, dw);
        check_val({tag, ".mosi_idle"}, mosi_bad, 0);
        $display("frame %s: sent %0h received %0h rises %0d", tag, word & mask, rx & mask, nrise);
    endtask

    initial begin
        logic [4:0] o;
        int gap, first_gap, ndone, w;
        bit seen_low, done_seen;

        drive(0, 1'b0, 8'h0);
        drive(1, 1'b0, 8'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("a_reset_hold", outs(0), 5'b11000);
        check_val("b_reset_hold", outs(1), 5'b11000);
        rst = 1'b0;
        @(negedge clk);
        check_val("a_reset_idle", outs(0), 5'b11000);
        check_val("b_reset_idle", outs(1), 5'b11000);
        $display("reset: a=%b b=%b", outs(0), outs(1));

        run_frame(0, 2, 4, 8'h1, 0, 8'h0, 0, 0, "a_0001");
        run_frame(0, 2, 4, 8'hA, 2, 8'h5, 0, 0, "a_1010_chg");
        run_frame(0, 2, 4, 8'h6, 0, 8'h0, 5, 20, "a_ignore_start");

        // Reset mid-frame, with start asserted alongside reset.
        done_seen = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 8'hC);
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            o = outs(0);
            if (o[0]) done_seen = 1'b1;
            if (t == 9) check_val("a_rst.pre_ss", o[4], 1'b0);
            if (t == 11 || t == 12) check_val($sformatf("a_rst.t%0d", t), o, 5'b11000);
            if (t == 13) check_val("a_rst.t13", o, 5'b11000);
            if (t == 1) drive(0, 1'b0, 8'hC);
            if (t == 10) begin
                rst = 1'b1;
                drive(0, 1'b1, 8'hC);
            end
            if (t == 12) begin
                rst = 1'b0;
                drive(0, 1'b0, 8'hC);
            end
        end
        check_val("a_rst.no_done", done_seen, 0);
        $display("reset mid-frame: done_seen=%0b", done_seen);
        run_frame(0, 2, 4, 8'h9, 0, 8'h0, 0, 0, "a_after_rst");

        // start held high: back-to-back frames.
        gap = 0; first_gap = -1; ndone = 0; seen_low = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 8'h6);
        for (int t = 1; t <= 44; t++) begin
            @(negedge clk);
            o = outs(0);
            if (o[0]) ndone++;
            if (!o[4]) begin
                if (seen_low && gap > 0 && first_gap < 0) first_gap = gap;
                seen_low = 1'b1;
                gap = 0;
            end else if (seen_low) begin
                gap++;
            end
        end
        drive(0, 1'b0, 8'h6);
        check_val("a_b2b.gap", first_gap, 3);
        check_val("a_b2b.done_count", ndone, 2);
        o = outs(0);
        for (w = 0; w < 80 && o[1]; w++) begin
            @(negedge clk);
            o = outs(0);
        end
        check_val("a_b2b.drain_busy", o[1], 1'b0);
        $display("back-to-back: gap=%0d dones=%0d drain=%0d", first_gap, ndone, w);

        run_frame(1, 1, 8, 8'hA5, 0, 8'h0, 0, 0, "b_a5");
        run_frame(1, 1, 8, 8'h3C, 1, 8'hFF, 0, 0, "b_3c_chg");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
